// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: PS/2 keyboard receiver with deglitch, frame checking and FWFT scan-code FIFO.
// Optional prefix decoding: define PS2_RX_PREFIX_DECODE_EN to fold E0/F0 into entry flags.
module ps2_keyboard_rx #(
   parameter int FILTER    = 4,
   parameter int TIMEOUT   = 50000,
   parameter int FIFO_BITS = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       rd,
   output logic       valid,
   output logic [7:0] code,
   output logic       extended,
   output logic       released,
   output logic       frame_err,
   output logic       overflow
);
   localparam int FW = $clog2(FILTER);
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
   state_t state;
   logic [1:0] clk_s, dat_s;
   logic fclk;
   logic [FW-1:0] fcnt;
   logic [15:0] tcnt;
   logic [2:0] bcnt;
   logic [7:0] shift;
   logic par_ok;
   logic ext_f, rel_f;
   logic fall, bit_in, timeout, stop_ok, bad, pfx, push, pop, full, empty;
   logic [FIFO_BITS:0] wp, rp;
   logic [9:0] mem [2**FIFO_BITS];
   logic [9:0] head;

   assign bit_in  = dat_s[1];
   assign fall    = fclk && !clk_s[1] && fcnt == FW'(FILTER - 1);
   assign timeout = !fall && state != IDLE && tcnt == 16'(TIMEOUT - 1);
   assign stop_ok = fall && state == STOP && bit_in && par_ok;
   assign bad     = (fall && state == IDLE && bit_in) || (fall && state == STOP && !(bit_in && par_ok)) || timeout;
   assign empty   = wp == rp;
   assign full    = wp[FIFO_BITS] != rp[FIFO_BITS] && wp[FIFO_BITS-1:0] == rp[FIFO_BITS-1:0];
   assign pop     = rd && !empty;
   assign push    = stop_ok && !pfx;
   assign valid   = !empty;
   assign head    = mem[rp[FIFO_BITS-1:0]];
   assign {extended, released, code} = valid ? head : 10'd0;

   // Resynchronise both pins and let the clock change only after FILTER stable samples
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         clk_s <= 2'b11;
         dat_s <= 2'b11;
         fclk  <= 1'b1;
         fcnt  <= '0;
      end else begin
         clk_s <= {clk_s[0], ps2_clk};
         dat_s <= {dat_s[0], ps2_data};
         if (clk_s[1] == fclk)
            fcnt <= '0;
         else if (fcnt == FW'(FILTER - 1)) begin
            fclk <= clk_s[1];
            fcnt <= '0;
         end else
            fcnt <= fcnt + 1'b1;
      end

   // Frame deserialiser with stall timeout and registered error/overflow pulses
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state     <= IDLE;
         shift     <= '0;
         bcnt      <= '0;
         par_ok    <= 1'b0;
         tcnt      <= '0;
         frame_err <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         frame_err <= bad;
         overflow  <= push && full && !pop;
         tcnt      <= (state == IDLE || fall) ? 16'd0 : tcnt + 16'd1;
         if (timeout)
            state <= IDLE;
         else if (fall)
            case (state)
               IDLE: if (!bit_in) begin
                  state <= DATA;
                  shift <= '0;
                  bcnt  <= '0;
               end
               DATA: begin
                  shift <= {bit_in, shift[7:1]};
                  bcnt  <= bcnt + 3'd1;
                  if (bcnt == 3'd7) state <= PARITY;
               end
               PARITY: begin
                  par_ok <= ^{shift, bit_in};
                  state  <= STOP;
               end
               STOP: state <= IDLE;
            endcase
      end

`ifdef PS2_RX_PREFIX_DECODE_EN
   assign pfx = shift == 8'hE0 || shift == 8'hF0;
   // Prefix flags accumulate over E0/F0 and clear after any other good byte or a bad frame
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         ext_f <= 1'b0;
         rel_f <= 1'b0;
      end else begin
         ext_f <= !bad && (stop_ok ? shift == 8'hE0 || (shift == 8'hF0 && ext_f) : ext_f);
         rel_f <= !bad && (stop_ok ? shift == 8'hF0 || (shift == 8'hE0 && rel_f) : rel_f);
      end
`else
   assign pfx   = 1'b0;
   assign ext_f = 1'b0;
   assign rel_f = 1'b0;
`endif

   // FIFO pointers; a push into a full FIFO only lands when a pop frees a slot the same cycle
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (push && (!full || pop)) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
      end

   // FIFO storage, written alongside the write-pointer advance
   always_ff @(posedge clk)
      if (push && (!full || pop)) mem[wp[FIFO_BITS-1:0]] <= {ext_f, rel_f, shift};
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb_ps2_keyboard_rx: scoreboard bench for ps2_keyboard_rx.
module tb_ps2_keyboard_rx;
   localparam int FILTER = 4;
   localparam int TIMEOUT = 300;
   localparam int FIFO_BITS = 3;
   logic clk = 0, reset = 1, ps2_clk = 1, ps2_data = 1, rd = 0;
   logic valid, extended, released, frame_err, overflow;
   logic [7:0] code;
   int checks = 0, fails = 0, cyc = 0, err_cnt = 0, ovf_cnt = 0, last_fall = 0;
   bit auto_rd = 1, fe_prev = 0, ov_prev = 0;
   logic [9:0] exp_q[$];

   ps2_keyboard_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT), .FIFO_BITS(FIFO_BITS)) dut (
      .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd(rd),
      .valid(valid), .code(code), .extended(extended), .released(released),
      .frame_err(frame_err), .overflow(overflow));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic void check(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   // monitor: pops and compares head entries, counts and width-checks pulses
   always @(negedge clk) begin
      if (reset) begin
         rd = 0;
         fe_prev = 0;
         ov_prev = 0;
      end else begin
         if (frame_err) begin check("frame_err_width", int'(fe_prev), 0); err_cnt++; end
         if (overflow) begin check("overflow_width", int'(ov_prev), 0); ovf_cnt++; end
         fe_prev = frame_err;
         ov_prev = overflow;
         if (rd) rd = 0;
         else if (valid && auto_rd) begin
            if (exp_q.size() == 0) check("unexpected_entry", int'({extended, released, code}), -1);
            else check("entry", int'({extended, released, code}), int'(exp_q.pop_front()));
            rd = 1;
         end
      end
   end

   task automatic ps2_bit(input logic b);
      @(negedge clk) ps2_data = b;
      repeat (5) @(negedge clk);
      ps2_clk = 0;
      last_fall = cyc;
      repeat (10) @(negedge clk);
      ps2_clk = 1;
      repeat (5) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic bad_par);
      ps2_bit(0);
      for (int i = 0; i < 8; i++) ps2_bit(d[i]);
      ps2_bit((~^d) ^ bad_par);
      ps2_bit(1);
      repeat (20) @(negedge clk);
   endtask

   task automatic good(input logic [7:0] d);
      exp_q.push_back({2'b00, d});
      send_frame(d, 0);
   endtask

   task automatic drain(input string nm);
      for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
      repeat (4) @(negedge clk);
      check(nm, exp_q.size(), 0);
      check({nm, "_valid"}, int'(valid), 0);
   endtask

   task automatic check_idle_outputs(input string nm);
      check({nm, "_valid"}, int'(valid), 0);
      check({nm, "_code"}, int'(code), 0);
      check({nm, "_ext"}, int'(extended), 0);
      check({nm, "_rel"}, int'(released), 0);
      check({nm, "_ferr"}, int'(frame_err), 0);
      check({nm, "_ovf"}, int'(overflow), 0);
   endtask

   initial begin
      int e0, t0, dt;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      reset = 0;
      repeat (5) @(negedge clk);
      good(8'h1C);
      drain("basic");
`ifdef PS2_RX_PREFIX_DECODE_EN
      exp_q.push_back({2'b11, 8'h74});
      send_frame(8'hE0, 0);
      send_frame(8'hF0, 0);
      send_frame(8'h74, 0);
`else
      good(8'hE0);
      good(8'hF0);
      good(8'h74);
`endif
      drain("prefix");
      e0 = err_cnt;
      send_frame(8'h1C, 1);
      check("parity_err_count", err_cnt - e0, 1);
      check("parity_valid", int'(valid), 0);
      good(8'h1C);
      drain("after_parity");
      auto_rd = 0;
      for (int i = 1; i <= 9; i++) begin
         if (i <= 8) exp_q.push_back({2'b00, 8'(i)});
         send_frame(8'(i), 0);
      end
      check("overflow_count", ovf_cnt, 1);
      check("full_valid", int'(valid), 1);
      auto_rd = 1;
      drain("overflow_drain");
      e0 = err_cnt;
      for (int i = 0; i < 5; i++) ps2_bit(i == 0 ? 1'b0 : 1'b1);
      t0 = last_fall;
      dt = -1;
      for (int i = 0; i < TIMEOUT + 100; i++) begin
         @(negedge clk);
         if (frame_err) begin dt = cyc - t0; break; end
      end
      check("timeout_seen", int'(dt >= TIMEOUT + FILTER + 1 && dt <= TIMEOUT + FILTER + 3), 1);
      repeat (5) @(negedge clk);
      check("timeout_err_count", err_cnt - e0, 1);
      good(8'h5A);
      drain("after_timeout");
      e0 = err_cnt;
      ps2_clk = 0;
      repeat (FILTER - 2) @(negedge clk);
      ps2_clk = 1;
      repeat (30) @(negedge clk);
      check("glitch_err", err_cnt - e0, 0);
      good(8'h29);
      drain("after_glitch");
      for (int i = 0; i < 4; i++) ps2_bit(1'b0);
      reset = 1;
      #1;
      check_idle_outputs("midreset");
      repeat (3) @(negedge clk);
      reset = 0;
      repeat (5) @(negedge clk);
      check("midreset_err", err_cnt - e0, 0);
      good(8'h33);
      drain("after_reset");
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
